mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of storage; depth is 2**ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, number of wait states inserted before each response.
REQ-003 Parameter BIG_ENDIAN, default 1; 1 puts the MSB at the lowest address, 0 puts the LSB at the lowest address.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_write  input  1  1 = store, 0 = load.
REQ-010 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-011 req_unsigned  input  1  load only: 1 = zero-extend, 0 = sign-extend.
REQ-012 req_addr  input  32  byte address.
REQ-013 req_wdata  input  32  store data; the low byte or half is used for sub-word stores.
REQ-014 rsp_valid  output  1  single-cycle response pulse.
REQ-015 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-016 rsp_err  output  1  request rejected: misaligned, out of range, or reserved size.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-018 Accept: req_valid && req_ready at a rising edge captures addr, size, write, unsigned and wdata; later input changes SHALL have no effect on that request.
REQ-019 After accept, the FSM SHALL go IDLE->WAIT if WAIT_CYCLES>0, else IDLE->RESP.
REQ-020 WAIT SHALL count WAIT_CYCLES cycles, then go to RESP.
REQ-021 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; rsp_valid arrives WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 The next request SHALL be acceptable in the cycle after RESP; no back-to-back accept occurs during WAIT or RESP.
REQ-023 Errors: half at an odd address, word with addr[1:0]!=0, any address >= 2**ADDR_W, or size 3.
REQ-024 An erroring request SHALL go directly to RESP (latency 1), with rsp_err=1 and rsp_rdata=0, and SHALL NOT write storage.
REQ-025 A store SHALL commit on the RESP-entry edge, writing only the addressed 1, 2 or 4 bytes in the BIG_ENDIAN ordering.
REQ-026 A load SHALL read storage on the RESP-entry edge.
REQ-027 Load extension: bit 7 (byte) or bit 15 (half) SHALL be replicated when req_unsigned=0; zeros SHALL fill when req_unsigned=1; words are unchanged.
REQ-028 A store SHALL return rsp_err=0 and rsp_rdata=0.
REQ-029 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-030 A load after a store to the same address SHALL return the stored value.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear the wait counter.
REQ-032 Reset during WAIT SHALL abort the request: no store commit and no response.
REQ-033 Storage contents SHALL NOT be cleared by reset.
REQ-034 Requests presented while reset=1 SHALL be ignored.

Structure
REQ-035 Package mem_access_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the WAIT_CYCLES counter width constant.
REQ-036 Storage SHALL be a sub-module mem_byte_ram: a 2**ADDR_W x 8 array with 4 byte lanes, per-lane write enables, and a combinational 4-byte read.
REQ-037 Alignment checking, lane steering and extension SHALL live in mem_access_unit.

Verification
REQ-038 WAIT_CYCLES=2: word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-039 BIG_ENDIAN=1: from the state above, byte load at 0x10 signed -> 0xFFFFFFDE; byte load at 0x13 unsigned -> 0x000000EF.
REQ-040 Half store 0x8001 to 0x22, then signed half load 0x22 -> 0xFFFF8001; unsigned half load -> 0x00008001; bytes at 0x20 and 0x21 remain unchanged.
REQ-041 Word load at 0x06, half load at 0x05, word load at 0x400 (ADDR_W=10), and any size-3 request -> each gives err=1, rdata=0, latency 1, memory unchanged.
REQ-042 Word store to 0x30 with reset pulsed during WAIT -> no rsp_valid, req_ready=1 the cycle after reset, and a subsequent load of 0x30 returns the old data.
REQ-043 WAIT_CYCLES=0 with continuous req_valid -> one accept every 2 cycles, and rsp_valid never asserted on two consecutive cycles.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// FSM state type, wait-counter width and byte-swap helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bus of the memory access unit.
//   req_valid/req_ready : request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid, rsp_rdata, rsp_err : single-cycle response
// master = requester side, slave = mem_access_unit side.
interface mem_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_byte_ram.sv
// Byte-organised storage, 2**ADDR_W bytes, accessed one aligned word at a time.
//   clk   : write clock
//   we    : per-lane write enables (lane 0 = lowest byte address)
//   waddr : word index
//   wdata : lane data, lane n in bits [8n+7:8n]
//   rdata : combinational read of the 4 lanes at waddr
module mem_byte_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-3:0] waddr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we[0]) mem[{waddr, 2'd0}] <= wdata[7:0];
        if (we[1]) mem[{waddr, 2'd1}] <= wdata[15:8];
        if (we[2]) mem[{waddr, 2'd2}] <= wdata[23:16];
        if (we[3]) mem[{waddr, 2'd3}] <= wdata[31:24];
    end

    always_comb begin
        rdata = {mem[{waddr, 2'd3}], mem[{waddr, 2'd2}],
                 mem[{waddr, 2'd1}], mem[{waddr, 2'd0}]};
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a byte RAM, with configurable wait states,
// alignment/range checking, endian lane steering and load extension.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : request/response bus (slave side)
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] LAST_CNT =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                state, state_n;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;

    logic        cap_write, cap_unsigned;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr, cap_wdata;

    logic        cur_write, cur_unsigned;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  off;

    logic        cur_err, accept, enter_resp;
    logic [3:0]  lane_we, ram_we;
    logic [31:0] lane_wdata, ram_rdata, load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // With zero wait states the RESP-entry edge is the accept edge itself,
    // so the request is taken straight from the bus while IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            cur_write    = bus.req_write;
            cur_unsigned = bus.req_unsigned;
            cur_size     = bus.req_size;
            cur_addr     = bus.req_addr;
            cur_wdata    = bus.req_wdata;
        end else begin
            cur_write    = cap_write;
            cur_unsigned = cap_unsigned;
            cur_size     = cap_size;
            cur_addr     = cap_addr;
            cur_wdata    = cap_wdata;
        end
        off = cur_addr[1:0];
    end

    always_comb begin
        cur_err = |(cur_addr >> ADDR_W);
        case (cur_size)
            SZ_HALF: if (cur_addr[0])    cur_err = 1'b1;
            SZ_WORD: if (|cur_addr[1:0]) cur_err = 1'b1;
            SZ_RSVD:                     cur_err = 1'b1;
            default: ;
        endcase
    end

    // Store lane steering; lane 0 is the lowest byte address.
    always_comb begin
        lane_we    = '0;
        lane_wdata = '0;
        case (cur_size)
            SZ_BYTE: begin
                lane_we    = 4'b0001 << off;
                lane_wdata = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_we    = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{BIG_ENDIAN ? bswap16(cur_wdata[15:0]) : cur_wdata[15:0]}};
            end
            SZ_WORD: begin
                lane_we    = '1;
                lane_wdata = BIG_ENDIAN ? bswap32(cur_wdata) : cur_wdata;
            end
            default: ;
        endcase
    end

    // Load lane selection and extension.
    always_comb begin
        case (off)
            2'd0:    ld_byte = ram_rdata[7:0];
            2'd1:    ld_byte = ram_rdata[15:8];
            2'd2:    ld_byte = ram_rdata[23:16];
            default: ld_byte = ram_rdata[31:24];
        endcase
        ld_half = off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        if (BIG_ENDIAN) ld_half = bswap16(ld_half);
        case (cur_size)
            SZ_BYTE: load_data = cur_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = cur_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = BIG_ENDIAN ? bswap32(ram_rdata) : ram_rdata;
        endcase
    end

    always_comb begin
        state_n        = state;
        wait_cnt_n     = wait_cnt;
        accept         = 1'b0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_rdata  = '0;
        bus.rsp_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (cur_err || WAIT_CYCLES == 0) begin
                        state_n = ST_RESP;
                    end else begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == LAST_CNT) state_n = ST_RESP;
                else                      wait_cnt_n = wait_cnt + WAIT_CNT_W'(1);
            end
            ST_RESP: begin
                state_n       = ST_IDLE;
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rsp_rdata_q;
                bus.rsp_err   = rsp_err_q;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_n == ST_RESP) && (state != ST_RESP);
    assign ram_we     = (enter_resp && cur_write && !cur_err && !reset) ? lane_we : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            cap_write    <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_size     <= '0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if (accept) begin
                cap_write    <= bus.req_write;
                cap_unsigned <= bus.req_unsigned;
                cap_size     <= bus.req_size;
                cap_addr     <= bus.req_addr;
                cap_wdata    <= bus.req_wdata;
            end
            if (enter_resp) begin
                rsp_err_q   <= cur_err;
                rsp_rdata_q <= (cur_write || cur_err) ? '0 : load_data;
            end
        end
    end

    mem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (cur_addr[ADDR_W-1:2]),
        .wdata (lane_wdata),
        .rdata (ram_rdata)
    );

endmodule
